// File: rtl/ifu_pkg.sv
// Shared defaults and the fetch-queue entry layout for the instruction prefetch unit.
package ifu_pkg;
  localparam int unsigned IFU_DATA_W = 32;
  localparam int unsigned IFU_ADDR_W = 8;
  localparam int unsigned IFU_DEPTH  = 4;
  localparam logic [IFU_DATA_W-1:0] IFU_RESET_PC = '0;

  typedef struct packed {
    logic [IFU_DATA_W-1:0] pc;
    logic [IFU_DATA_W-1:0] data;
    logic                  filled;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: entries allocated at request time, filled in order by responses, popped by decode.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned DATA_W = IFU_DATA_W,
  parameter int unsigned DEPTH  = IFU_DEPTH,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned PTR_W = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              alloc_i,
  input  logic [DATA_W-1:0] alloc_pc_i,
  input  logic              fill_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              pop_i,
  output logic [PTR_W-1:0]  wr_ptr_o,
  output logic [PTR_W-1:0]  fill_ptr_o,
  output logic [PTR_W-1:0]  rd_ptr_o,
  output logic              head_filled_o,
  output logic [DATA_W-1:0] head_pc_o,
  output logic [DATA_W-1:0] head_data_o
);
  logic [PTR_W-1:0]  wr_ptr_q, fill_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  logic [IDX_W-1:0]  wr_idx, fill_idx, rd_idx;

  assign wr_idx   = wr_ptr_q[IDX_W-1:0];
  assign fill_idx = fill_ptr_q[IDX_W-1:0];
  assign rd_idx   = rd_ptr_q[IDX_W-1:0];

  // Allocate, fill and pop always target distinct slots, so all three may land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      filled_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      filled_q   <= '0;
    end else begin
      if (alloc_i) begin
        pc_q[wr_idx]     <= alloc_pc_i;
        filled_q[wr_idx] <= 1'b0;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (fill_i) begin
        data_q[fill_idx]   <= fill_data_i;
        filled_q[fill_idx] <= 1'b1;
        fill_ptr_q         <= fill_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        filled_q[rd_idx] <= 1'b0;
        rd_ptr_q         <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign wr_ptr_o      = wr_ptr_q;
  assign fill_ptr_o    = fill_ptr_q;
  assign rd_ptr_o      = rd_ptr_q;
  assign head_filled_o = filled_q[rd_idx];
  assign head_pc_o     = pc_q[rd_idx];
  assign head_data_o   = data_q[rd_idx];
endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: issues sequential fetches, tracks responses to discard after a
// redirect, and presents the queue head to decode.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned DATA_W = IFU_DATA_W,
  parameter int unsigned ADDR_W = IFU_ADDR_W,
  parameter int unsigned DEPTH  = IFU_DEPTH,
  parameter logic [DATA_W-1:0] RESET_PC = IFU_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [DATA_W-1:0] instr_pc,
  output logic [DATA_W-1:0] instr_pc_add_4
);
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [PTR_W-1:0]  wr_ptr, fill_ptr, rd_ptr;
  logic              head_filled;
  logic [DATA_W-1:0] head_pc, head_data;
  logic [PTR_W:0]    used;
  logic              req_fire, fill_en, pop_en;

  // Slots owed to responses that will be discarded still count against capacity.
  assign used           = {1'b0, wr_ptr - rd_ptr} + {1'b0, drop_cnt_q};
  assign imem_req_valid = rst_n && !redirect_valid && (used < (PTR_W+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q[ADDR_W+1:2];
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign fill_en = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid && (fill_ptr != wr_ptr);
  assign instr_valid = head_filled && (rd_ptr != wr_ptr) && !redirect_valid;
  assign pop_en      = instr_valid && instr_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~DATA_W'(3);
      drop_cnt_d = drop_cnt_q + (wr_ptr - fill_ptr) - PTR_W'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + DATA_W'(4);
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (redirect_valid),
    .alloc_i       (req_fire),
    .alloc_pc_i    (fetch_pc_q),
    .fill_i        (fill_en),
    .fill_data_i   (imem_rsp_data),
    .pop_i         (pop_en),
    .wr_ptr_o      (wr_ptr),
    .fill_ptr_o    (fill_ptr),
    .rd_ptr_o      (rd_ptr),
    .head_filled_o (head_filled),
    .head_pc_o     (head_pc),
    .head_data_o   (head_data)
  );

  assign instr_pc       = head_pc;
  assign instr_data     = head_data;
  assign instr_pc_add_4 = head_pc + DATA_W'(4);
endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with an in-order memory model and a PC/data scoreboard.
module tb_ifu_prefetch;
  import ifu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [DW-1:0] redirect_pc = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b1;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [DW-1:0] imem_rsp_data = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b1;
  logic [DW-1:0] instr_data;
  logic [DW-1:0] instr_pc;
  logic [DW-1:0] instr_pc_add_4;

  always #5 clk = ~clk;

  ifu_prefetch #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_pc_add_4 (instr_pc_add_4)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  pend_t         pend_q[$];
  fetch_entry_t  exp_q[$];
  int            n_assert = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            lat = 1;
  int            pops = 0;
  int            accepts = 0;
  logic [DW-1:0] model_pc = '0;
  logic [DW-1:0] last_pc = '0;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {8'h5A, ~a, 8'hC3, a};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: memory answers, outputs are scored, the model follows the handshakes.
  task automatic step();
    fetch_entry_t e;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (redirect_valid) begin
      chk("redirect_blocks_req", imem_req_valid, 0);
      chk("redirect_blocks_instr", instr_valid, 0);
    end
    if (instr_valid && instr_ready) begin
      pops++;
      last_pc = instr_pc;
      chk("scoreboard_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr_data", instr_data, e.data);
        chk("instr_pc_add_4", instr_pc_add_4, e.pc + 32'd4);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      accepts++;
      chk("req_addr", imem_req_addr, model_pc[AW+1:2]);
      pend_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      exp_q.push_back('{pc: model_pc, data: memf(model_pc[AW+1:2]), filled: 1'b1});
      model_pc = model_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
      model_pc = redirect_pc & ~32'h3;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int start = pops;
    int k = 0;
    while (pops - start < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, pops - start >= n, 1);
  endtask

  task automatic do_redirect(input logic [DW-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int first_pop;
    int k;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);

    // Release reset: the very next edge must carry a request to RESET_PC.
    rst_n = 1'b1;
    #1;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 0);
    first_pop = -1;
    for (int i = 0; i < 10; i++) begin
      int p = pops;
      step();
      if (pops != p && first_pop < 0) first_pop = i;
    end
    chk("first_pop_step", first_pop, 2);
    chk("pops_back_to_back", pops, 8);

    // Decode stalled: exactly DEPTH requests, then none until a pop.
    instr_ready = 1'b0;
    do_redirect(32'h40);
    accepts = 0;
    repeat (12) step();
    chk("full_accepts", accepts, DEPTH);
    chk("full_no_req", imem_req_valid, 0);
    instr_ready = 1'b1;
    step();
    chk("pop_in_full", last_pc, 32'h40);
    instr_ready = 1'b0;
    #1;
    chk("req_after_pop", imem_req_valid, 1);
    instr_ready = 1'b1;
    wait_pops(3, 20, "drain_after_full");

    // Misaligned redirect with two fetches in flight.
    lat = 3;
    k = 0;
    while (pend_q.size() < 2 && k < 20) begin
      step();
      k++;
    end
    chk("two_in_flight", pend_q.size() >= 2, 1);
    do_redirect(32'h103);
    wait_pops(1, 30, "redirect_103_arrive");
    chk("redirect_103_pc", last_pc, 32'h100);

    // Redirect coinciding with a response and an attempted pop.
    lat = 1;
    wait_pops(4, 30, "stream_lat1");
    #1;
    chk("stream_instr_valid", instr_valid, 1);
    chk("stream_rsp_due", pend_q.size() > 0 && pend_q[0].due <= cyc, 1);
    do_redirect(32'h200);
    wait_pops(3, 30, "redirect_200_drain");
    chk("redirect_200_last", last_pc, 32'h208);

    // Back-to-back redirects: the second target wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    step();
    redirect_pc    = 32'h380;
    step();
    redirect_valid = 1'b0;
    wait_pops(1, 30, "b2b_arrive");
    chk("b2b_pc", last_pc, 32'h380);
    wait_pops(2, 30, "b2b_drain");

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFE);
    wait_pops(1, 30, "wrap_first");
    chk("wrap_first_pc", last_pc, 32'hFFFF_FFFC);
    wait_pops(1, 30, "wrap_second");
    chk("wrap_second_pc", last_pc, 32'h0);

    // Reset while full with three responses outstanding.
    lat = 6;
    instr_ready = 1'b0;
    do_redirect(32'h500);
    accepts = 0;
    k = 0;
    while (!(accepts == DEPTH && pend_q.size() == 3) && k < 40) begin
      step();
      k++;
    end
    chk("full_inflight_reached", accepts == DEPTH && pend_q.size() == 3, 1);
    chk("pre_reset_instr_valid", instr_valid, 1);
    chk("pre_reset_instr_pc", instr_pc, 32'h500);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req_valid", imem_req_valid, 0);
    chk("async_rst_instr_valid", instr_valid, 0);
    pend_q.delete();
    exp_q.delete();
    model_pc = '0;
    imem_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    lat = 1;
    instr_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("restart_req_valid", imem_req_valid, 1);
    chk("restart_req_addr", imem_req_addr, 0);
    wait_pops(4, 20, "restart_drain");
    chk("restart_last_pc", last_pc, 32'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
